// File: rtl/circuit_response_checker.sv
// Response checker for a 4-input / 2-output logic circuit.
// Accepts one stimulus vector per handshake and waits a settle time.
// Then samples f1/f2 and compares them against golden truth tables.
// Accumulates mismatch count, first failing vector and per-vector coverage.
// All results are registered. A comparison is committed on the clock edge that
// enters COMPARE, so cmp_done, cmp_fail and the updated results appear together
// during the COMPARE cycle. The source holds f1/f2 stable from accept through COMPARE.
module circuit_response_checker #(
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] EXP_F1        = 16'hF444,
    parameter logic [15:0] EXP_F2        = 16'h88F8,
    parameter int          ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clear,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [3:0]       vec_in,
    input  logic             f1,
    input  logic             f2,
    output logic             cmp_done,
    output logic             cmp_fail,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [3:0]       first_fail_vec,
    output logic [15:0]      coverage,
    output logic             all_covered
);

    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_VEC = 2'd1,
        SETTLE   = 2'd2,
        COMPARE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       vec_r;
    logic             accept_s;
    logic             fire_s;
    logic             fail_s;
    logic             clear_s;
    logic [15:0]      cov_next_s;

    // Next-state decode; accept and compare-fire strobes come from the same decode.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        fire_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (run) begin
                    next_state_s = WAIT_VEC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT_VEC: begin
                if (!run) begin
                    next_state_s = IDLE;
                end else if (vec_valid) begin
                    next_state_s = SETTLE;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = WAIT_VEC;
                end
            end
            SETTLE: begin
                if (!run) begin
                    next_state_s = IDLE;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    next_state_s = COMPARE;
                    fire_s       = 1'b1;
                end else begin
                    next_state_s = SETTLE;
                end
            end
            COMPARE: begin
                if (!run) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_VEC;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Golden comparison for the latched vector and next coverage map.
    always_comb begin
        fail_s     = (f1 != EXP_F1[vec_r]) | (f2 != EXP_F2[vec_r]);
        clear_s    = (state_r == IDLE) & ~run & clear;
        cov_next_s = coverage;
        if (fire_s) begin
            cov_next_s = coverage | (16'd1 << vec_r);
        end else begin
            cov_next_s = coverage;
        end
    end

    // State register plus handshake and compare strobes, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            vec_ready <= 1'b0;
            cmp_done  <= 1'b0;
            cmp_fail  <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            vec_ready <= (next_state_s == WAIT_VEC);
            cmp_done  <= fire_s;
            cmp_fail  <= fire_s & fail_s;
        end
    end

    // Latch the accepted vector and run the settle countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
            vec_r <= 4'd0;
        end else if (accept_s) begin
            cnt_r <= CNT_LOAD;
            vec_r <= vec_in;
        end else if ((state_r == SETTLE) && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

    // Result accumulation: clear in IDLE, otherwise update on each committed comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count        <= {ERR_W{1'b0}};
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 4'd0;
            coverage         <= 16'd0;
            all_covered      <= 1'b0;
        end else if (clear_s) begin
            err_count        <= {ERR_W{1'b0}};
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 4'd0;
            coverage         <= 16'd0;
            all_covered      <= 1'b0;
        end else if (fire_s) begin
            coverage    <= cov_next_s;
            all_covered <= &cov_next_s;
            if (fail_s) begin
                if (!(&err_count)) begin
                    err_count <= err_count + ERR_W'(1);
                end
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec   <= vec_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_circuit_response_checker.sv
// Self-checking bench for circuit_response_checker: directed steps plus random
// vectors, compared against a truth-table reference model kept in the bench.
module tb_circuit_response_checker;

    localparam int SETTLE  = 4;
    localparam int ERR_W   = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic             clear = 1'b0;
    logic             vec_valid = 1'b0;
    logic             vec_ready;
    logic [3:0]       vec_in = 4'd0;
    logic             f1 = 1'b0;
    logic             f2 = 1'b0;
    logic             cmp_done;
    logic             cmp_fail;
    logic [ERR_W-1:0] err_count;
    logic             first_fail_valid;
    logic [3:0]       first_fail_vec;
    logic [15:0]      coverage;
    logic             all_covered;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int          m_err   = 0;
    bit          m_ffv   = 1'b0;
    logic [3:0]  m_ffvec = 4'd0;
    logic [15:0] m_cov   = 16'd0;

    circuit_response_checker #(
        .SETTLE_CYCLES(SETTLE),
        .EXP_F1(16'hF444),
        .EXP_F2(16'h88F8),
        .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .clear(clear),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_in(vec_in),
        .f1(f1), .f2(f2), .cmp_done(cmp_done), .cmp_fail(cmp_fail),
        .err_count(err_count), .first_fail_valid(first_fail_valid),
        .first_fail_vec(first_fail_vec), .coverage(coverage),
        .all_covered(all_covered)
    );

    always #5 clk = ~clk;

    function automatic logic mf1(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (a & b) | (c & ~d);
    endfunction

    function automatic logic mf2(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (~a & b) | (c & d);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_err = 0; m_ffv = 1'b0; m_ffvec = 4'd0; m_cov = 16'd0;
    endtask

    task automatic check_results(input string tag);
        check({tag, "_err"}, 32'(err_count), 32'(m_err));
        check({tag, "_ffv"}, 32'(first_fail_valid), 32'(m_ffv));
        check({tag, "_ffvec"}, 32'(first_fail_vec), 32'(m_ffvec));
        check({tag, "_cov"}, 32'(coverage), 32'(m_cov));
        check({tag, "_allcov"}, 32'(all_covered), 32'(m_cov == 16'hFFFF));
    endtask

    task automatic wait_ready();
        int waited = 0;
        while (vec_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", 32'(vec_ready), 32'd1);
    endtask

    // Called at a negedge; returns at a negedge with the checker ready again.
    task automatic do_vec(input logic [3:0] v, input logic vf1, input logic vf2, input bit hold);
        bit fail;
        wait_ready();
        vec_valid = 1'b1; vec_in = v; f1 = vf1; f2 = vf2;
        @(posedge clk);
        for (int n = 0; n <= SETTLE + 1; n++) begin
            @(negedge clk);
            if (n == 0 && !hold) vec_valid = 1'b0;
            if (n == SETTLE + 1) begin
                vec_valid = 1'b0;
                fail = (vf1 != mf1(v)) || (vf2 != mf2(v));
                m_cov[v] = 1'b1;
                if (fail) begin
                    if (m_err < ERR_MAX) m_err++;
                    if (!m_ffv) begin m_ffv = 1'b1; m_ffvec = v; end
                end
                check("cmp_done_hi", 32'(cmp_done), 32'd1);
                check("cmp_fail", 32'(cmp_fail), 32'(fail));
                check("ready_in_cmp", 32'(vec_ready), 32'd0);
                check_results("cmp");
            end else begin
                check("cmp_done_lo", 32'(cmp_done), 32'd0);
                check("ready_in_settle", 32'(vec_ready), 32'd0);
            end
        end
        @(negedge clk);
        check("ready_after", 32'(vec_ready), 32'd1);
        check("cmp_done_after", 32'(cmp_done), 32'd0);
    endtask

    initial begin
        logic [3:0] v;
        // T1 reset
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(vec_ready), 32'd0);
        check("rst_done", 32'(cmp_done), 32'd0);
        check_results("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(vec_ready), 32'd0);
        run = 1'b1;
        @(negedge clk);
        check("run_ready", 32'(vec_ready), 32'd1);

        // T2 passing vectors
        do_vec(4'b0000, 1'b0, 1'b0, 1'b0);
        do_vec(4'b1100, 1'b1, 1'b0, 1'b0);
        do_vec(4'b0010, 1'b1, 1'b0, 1'b0);
        do_vec(4'b0100, 1'b0, 1'b1, 1'b0);
        do_vec(4'b1111, 1'b1, 1'b1, 1'b0);
        check("t2_cov_const", 32'(coverage), 32'h9015);

        // T3 failing vectors
        do_vec(4'b1100, 1'b0, 1'b0, 1'b0);
        check("t3_ffvec_c", 32'(first_fail_vec), 32'hC);
        do_vec(4'b0100, 1'b1, 1'b1, 1'b0);
        check("t3_err2", 32'(err_count), 32'd2);

        // clear while running is ignored
        clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b0;
        check_results("clr_ignored");

        // T4 vec_valid held through SETTLE
        do_vec(4'b0001, 1'b0, 1'b0, 1'b1);

        // T5 abort mid-SETTLE
        wait_ready();
        vec_valid = 1'b1; vec_in = 4'b1000; f1 = 1'b1; f2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run = 1'b0; vec_valid = 1'b0;
        for (int i = 0; i < SETTLE + 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(cmp_done), 32'd0);
        end
        check("abort_ready", 32'(vec_ready), 32'd0);
        check_results("abort");
        run = 1'b1;
        @(negedge clk);

        // reset pulse mid-SETTLE
        wait_ready();
        vec_valid = 1'b1; vec_in = 4'b1010; f1 = 1'b0; f2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vec_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_ready", 32'(vec_ready), 32'd0);
        check("midrst_done", 32'(cmp_done), 32'd0);
        check("midrst_fail", 32'(cmp_fail), 32'd0);
        check_results("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_ready", 32'(vec_ready), 32'd1);

        // T6 saturation with random failing vectors, then full coverage
        for (int i = 0; i < 5; i++) begin
            v = 4'($urandom_range(0, 15));
            do_vec(v, ~mf1(v), mf2(v), 1'b0);
        end
        check("t6_sat", 32'(err_count), 32'(ERR_MAX));
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            do_vec(v, mf1(v) ^ 1'($urandom_range(0, 1)),
                   mf2(v) ^ 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check("t6_allcov", 32'(all_covered), 32'd1);

        // clear in IDLE
        run = 1'b0; clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        @(negedge clk);
        check_results("cleared");
        check("cleared_ready", 32'(vec_ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
